// File: rtl/odbiornik_uart.sv
// ============================================================================
//  odbiornik_uart : UART receiver, 8 data bits LSB first, optional parity, 1 stop
//  Rev 1.0
// ============================================================================
`default_nettype none

module odbiornik_uart #(
    parameter int BIT_CYCLES = 43,
    parameter int HALF       = 21
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       wejscie_odb,
    input  logic       czy_parz,
    input  logic       jaki_parz,
    output logic [7:0] odebrane,
    output logic       gotowe,
    output logic       blad_parz,
    output logic       blad_stopu,
    output logic       odbior
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] licznik;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_en;
    logic          par_odd;
    logic          par_err;
    logic          bit_end;

    assign bit_end = (licznik == BIT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= wejscie_odb;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            licznik    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_en     <= 1'b0;
            par_odd    <= 1'b0;
            par_err    <= 1'b0;
            odebrane   <= '0;
            gotowe     <= 1'b0;
            blad_parz  <= 1'b0;
            blad_stopu <= 1'b0;
            odbior     <= 1'b0;
        end else begin
            gotowe <= 1'b0;
            case (state)
                IDLE: begin
                    licznik <= '0;
                    if (!rx_s) begin
                        // Frame format is frozen here for the whole frame.
                        state   <= START;
                        par_en  <= czy_parz;
                        par_odd <= jaki_parz;
                        par_err <= 1'b0;
                        odbior  <= 1'b1;
                    end
                end
                START: begin
                    if (licznik == HALF_LAST) begin
                        licznik <= '0;
                        bit_idx <= '0;
                        if (rx_s) begin
                            state  <= IDLE;
                            odbior <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        licznik <= licznik + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        licznik <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= par_en ? PARITY : STOP;
                        end
                    end else begin
                        licznik <= licznik + CW'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        licznik <= '0;
                        par_err <= rx_s != ((^shreg) ^ par_odd);
                        state   <= STOP;
                    end else begin
                        licznik <= licznik + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        licznik    <= '0;
                        odebrane   <= shreg;
                        blad_parz  <= par_err;
                        blad_stopu <= ~rx_s;
                        gotowe     <= 1'b1;
                        if (rx_s) begin
                            state  <= IDLE;
                            odbior <= 1'b0;
                        end else begin
                            // Line held low: wait for idle so a break is not a new start.
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        licznik <= licznik + CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    licznik <= '0;
                    if (rx_s) begin
                        state  <= IDLE;
                        odbior <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    licznik <= '0;
                    odbior  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_odbiornik_uart.sv
// ============================================================================
//  tb_odbiornik_uart : scoreboard bench for the UART receiver
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_odbiornik_uart;

    localparam int BIT_CYCLES = 43;
    localparam int HALF       = 21;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       wejscie_odb = 1'b1;
    logic       czy_parz = 1'b0;
    logic       jaki_parz = 1'b0;
    logic [7:0] odebrane;
    logic       gotowe;
    logic       blad_parz;
    logic       blad_stopu;
    logic       odbior;

    odbiornik_uart #(
        .BIT_CYCLES (BIT_CYCLES),
        .HALF       (HALF)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .wejscie_odb (wejscie_odb),
        .czy_parz    (czy_parz),
        .jaki_parz   (jaki_parz),
        .odebrane    (odebrane),
        .gotowe      (gotowe),
        .blad_parz   (blad_parz),
        .blad_stopu  (blad_stopu),
        .odbior      (odbior)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       bp;
        logic       bs;
        int         k0;
        int         lat;
    } exp_t;

    exp_t queue_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic prev_gotowe = 1'b0;

    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: every gotowe pulse must match the oldest pending frame.
    always @(negedge CLK) begin
        if (RST_N && gotowe) begin
            check("pulse_single", {31'd0, prev_gotowe}, 32'd0);
            if (queue_exp.size() == 0) begin
                check("spurious_gotowe", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = queue_exp.pop_front();
                check("odebrane", {24'd0, odebrane}, {24'd0, e.data});
                check("blad_parz", {31'd0, blad_parz}, {31'd0, e.bp});
                check("blad_stopu", {31'd0, blad_stopu}, {31'd0, e.bs});
                check("latency", cyc - e.k0, e.lat);
            end
        end
        prev_gotowe = gotowe;
    end

    task automatic line_bit(input logic v);
        wejscie_odb = v;
        repeat (BIT_CYCLES) @(negedge CLK);
    endtask

    // Called at a negedge; flips the format inputs mid-frame when asked.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                              input logic flip);
        exp_t e;
        logic pe;
        logic po;
        pe     = czy_parz;
        po     = jaki_parz;
        e.data = d;
        e.bp   = pe ? (pbit != ((^d) ^ po)) : 1'b0;
        e.bs   = ~stopb;
        e.k0   = cyc + 1;
        e.lat  = pe ? (2 + HALF + 10 * BIT_CYCLES) : (2 + HALF + 9 * BIT_CYCLES);
        queue_exp.push_back(e);
        line_bit(1'b0);
        if (flip) begin
            czy_parz  = ~pe;
            jaki_parz = ~po;
        end
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        if (pe) line_bit(pbit);
        line_bit(stopb);
        czy_parz  = pe;
        jaki_parz = po;
    endtask

    initial begin
        int k0;
        repeat (3) @(negedge CLK);
        check("rst_odebrane", {24'd0, odebrane}, 32'd0);
        check("rst_gotowe", {31'd0, gotowe}, 32'd0);
        check("rst_blad_parz", {31'd0, blad_parz}, 32'd0);
        check("rst_blad_stopu", {31'd0, blad_stopu}, 32'd0);
        check("rst_odbior", {31'd0, odbior}, 32'd0);
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);

        // No parity, 0xA5
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        repeat (20) @(negedge CLK);

        // Even parity ok (with format inputs toggled mid-frame), odd ok, even with wrong bit
        czy_parz  = 1'b1;
        jaki_parz = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        jaki_parz = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        jaki_parz = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        repeat (20) @(negedge CLK);

        // Glitch shorter than half a bit
        k0 = cyc + 1;
        wejscie_odb = 1'b0;
        repeat (10) @(negedge CLK);
        wejscie_odb = 1'b1;
        while (cyc < k0 + 14) @(negedge CLK);
        check("glitch_odbior_busy", {31'd0, odbior}, 32'd1);
        while (cyc < k0 + 30) @(negedge CLK);
        check("glitch_odbior_idle", {31'd0, odbior}, 32'd0);
        check("glitch_odebrane_held", {24'd0, odebrane}, 32'h3C);
        check("glitch_blad_parz_held", {31'd0, blad_parz}, 32'd1);

        // Stop bit 0 followed by long low line
        czy_parz = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (200) @(negedge CLK);
        check("break_odbior_busy", {31'd0, odbior}, 32'd1);
        wejscie_odb = 1'b1;
        repeat (60) @(negedge CLK);
        check("break_odbior_idle", {31'd0, odbior}, 32'd0);

        // Reset in the middle of data bit 4
        wejscie_odb = 1'b0;
        repeat (BIT_CYCLES) @(negedge CLK);
        for (int i = 0; i < 4; i++) line_bit(i[0]);
        wejscie_odb = 1'b0;
        repeat (20) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("abort_odebrane", {24'd0, odebrane}, 32'd0);
        check("abort_blad_stopu", {31'd0, blad_stopu}, 32'd0);
        check("abort_odbior", {31'd0, odbior}, 32'd0);
        check("abort_gotowe", {31'd0, gotowe}, 32'd0);
        @(negedge CLK);
        wejscie_odb = 1'b1;
        RST_N = 1'b1;
        repeat (50) @(negedge CLK);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge CLK);

        // Back-to-back frames, odd parity
        czy_parz  = 1'b1;
        jaki_parz = 1'b1;
        send_frame(8'h00, ~^8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, ~^8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, ~^8'h55, 1'b1, 1'b0);

        for (int i = 0; i < 2000 && queue_exp.size() != 0; i++) @(negedge CLK);
        repeat (60) @(negedge CLK);
        check("queue_drained", queue_exp.size(), 32'd0);
        check("final_odbior", {31'd0, odbior}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/odbiornik_uart.md
Name: odbiornik_uart

Overview:
UART receiver, the receive-side counterpart of the team's UART transmitter. Frame format is idle-high, one start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1). Bit timing comes from an internal CLK-cycle counter matching the transmitter's 43-cycle bit period. A received byte is presented with a one-cycle valid strobe and error flags.

Parameters:
BIT_CYCLES, 43, CLK cycles per bit; must equal the transmitter bit period.
HALF, 21, cycles from start-edge detection to the start-bit mid-sample; must be less than BIT_CYCLES.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
wejscie_odb  input  1  serial line, asynchronous to CLK, idle high.
czy_parz  input  1  1 = frame carries a parity bit.
jaki_parz  input  1  0 = even (parity bit = XOR of data), 1 = odd (XNOR of data).
odebrane  output  8  last received byte; holds until next completed frame.
gotowe  output  1  one-cycle pulse: a frame completed and odebrane was updated.
blad_parz  output  1  parity mismatch in last completed frame.
blad_stopu  output  1  stop bit sampled 0 in last completed frame.
odbior  output  1  high while a frame is being received, from START through STOP and WAIT_IDLE.

Behaviour:
- Reset (async, RST_N=0): state IDLE, counters 0, synchronizer flops 1, odebrane=0, gotowe=0, blad_parz=0, blad_stopu=0, odbior=0. Reset mid-frame aborts the frame with no gotowe.
- Input path: two-flop synchronizer. rx_s is the second flop. The FSM uses only rx_s.
- Let k0 be the first CLK edge at which flop 1 captures 0. The FSM sees rx_s=0 at edge k0+2.
- States:
  - IDLE: when rx_s=0, go to START, licznik=0. czy_parz and jaki_parz are latched here and held for the whole frame.
  - START: sample at edge k0+2+HALF. If rx_s=1 (glitch), go to IDLE with no output change. Otherwise go to DATA, bit index 0, licznik=0.
  - DATA: sample every BIT_CYCLES edges. Data bit i is sampled at edge k0+2+HALF+(i+1)*BIT_CYCLES and shifted in LSB first. After bit 7, go to PARITY if the latched czy_parz=1, else STOP.
  - PARITY: sample one bit period later. Compare against the expected bit computed from the 8 received bits.
  - STOP: sample one bit period later. At that edge: odebrane ← shift register; blad_parz ← mismatch (0 if no parity); blad_stopu ← NOT rx_s; gotowe=1 for exactly the next cycle. Go to IDLE if rx_s=1, else WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break or line-low condition from starting new frames.
- Default timing: gotowe is high in the cycle after edge k0+453 with parity, or k0+410 without.
- The bit counter (licznik) wraps at BIT_CYCLES-1 → 0, width ceil(log2(BIT_CYCLES)).
- Error flags and odebrane update only on frame completion. They are never cleared by later false starts.
- Back-to-back frames: after the stop sample, IDLE can detect the next start edge. The next frame's start bit may begin immediately after the stop bit.
- Changing czy_parz or jaki_parz mid-frame does not affect the frame in progress.
- odbior=1 in all states except IDLE.

Test Plan:
1. No parity, send 0xA5 at 43 cycles/bit → gotowe pulse 1 cycle at k0+410, odebrane=0xA5, blad_parz=0, blad_stopu=0.
2. czy_parz=1, jaki_parz=0, send 0x3C with parity bit 0 → odebrane=0x3C, blad_parz=0. Repeat with jaki_parz=1 and parity bit 1 → blad_parz=0. Send 0x3C with parity bit 1 under even parity → blad_parz=1.
3. Glitch: wejscie_odb low for 10 cycles, then high → no gotowe, odbior returns to 0 at about k0+23, odebrane unchanged.
4. Stop bit forced 0, line then held low for 200 cycles → gotowe pulse, blad_stopu=1, odbior stays 1 until line high. No second frame is detected.
5. RST_N pulsed low during data bit 4 → all outputs 0 immediately. A following full frame 0x81 is received correctly.
6. Loopback with the team transmitter (czy_parz=1, jaki_parz=1), sending bytes 0x00, 0xFF, 0x55 back-to-back → three gotowe pulses, bytes match, no error flags.
